mem_port_arbiter: RTL

- Shares the single MMU request port (mem_*) between two Vicuna/Ibex requesters: instruction fetch (instr_*) and data/vector (data_*).
- Round-robin arbitration; one outstanding transaction at a time.
- The MMU has no grant and variable latency (SRAM, SPI flash, GPIO, timer), so the arbiter holds the downstream request stable until mem_rvalid_i.
- Returns each response to the requester that owns it.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one grant-less MMU port between instruction fetch and data.
// Optional watchdog on stalled MMU transactions: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic                mem_err_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_ownerInstr;
    logic                r_lastInstr;
    logic [ADDR_W-1:0]   r_memAddr;
    logic                r_memWe;
    logic [DATA_W/8-1:0] r_memBe;
    logic [DATA_W-1:0]   r_memWdata;
    logic [DATA_W-1:0]   r_instrRdata;
    logic                r_instrErr;
    logic [DATA_W-1:0]   r_dataRdata;
    logic                r_dataErr;
    logic                w_pickInstr;
    logic                w_pickData;
    logic                w_grant;
    logic                w_respTake;
    logic                w_timeout;

    // On a tie the requester that did not win last time takes the port.
    assign w_pickInstr = instr_req_i && (!data_req_i || !r_lastInstr);
    assign w_pickData  = data_req_i && !w_pickInstr;
    assign w_grant     = (r_state == IDLE) && (w_pickInstr || w_pickData);
    assign w_respTake  = (r_state == ISSUE) && (mem_rvalid_i || w_timeout);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0] r_timeoutCnt;

    assign w_timeout = (r_state == ISSUE) && !mem_rvalid_i &&
                       (r_timeoutCnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeoutCnt <= '0;
        end else if (w_grant) begin
            r_timeoutCnt <= '0;
        end else if (r_state == ISSUE) begin
            r_timeoutCnt <= r_timeoutCnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_nextState = ISSUE;
            ISSUE:   if (w_respTake) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request fields are captured at grant so the MMU sees a stable request until it responds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ownerInstr <= 1'b0;
            r_lastInstr  <= 1'b0;
            r_memAddr    <= '0;
            r_memWe      <= 1'b0;
            r_memBe      <= '0;
            r_memWdata   <= '0;
            r_instrRdata <= '0;
            r_instrErr   <= 1'b0;
            r_dataRdata  <= '0;
            r_dataErr    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ownerInstr <= w_pickInstr;
                r_lastInstr  <= w_pickInstr;
                if (w_pickInstr) begin
                    r_memAddr  <= instr_addr_i;
                    r_memWe    <= 1'b0;
                    r_memBe    <= '1;
                    r_memWdata <= '0;
                end else begin
                    r_memAddr  <= data_addr_i;
                    r_memWe    <= data_we_i;
                    r_memBe    <= data_be_i;
                    r_memWdata <= data_wdata_i;
                end
            end
            if (w_respTake) begin
                if (r_ownerInstr) begin
                    r_instrRdata <= w_timeout ? '0 : mem_rdata_i;
                    r_instrErr   <= w_timeout ? 1'b1 : mem_err_i;
                end else begin
                    r_dataRdata <= w_timeout ? '0 : mem_rdata_i;
                    r_dataErr   <= w_timeout ? 1'b1 : mem_err_i;
                end
            end
        end
    end

    assign instr_gnt_o    = (r_state == IDLE) && w_pickInstr;
    assign data_gnt_o     = (r_state == IDLE) && w_pickData;
    assign instr_rvalid_o = (r_state == RESP) && r_ownerInstr;
    assign data_rvalid_o  = (r_state == RESP) && !r_ownerInstr;
    assign instr_rdata_o  = r_instrRdata;
    assign instr_err_o    = r_instrErr;
    assign data_rdata_o   = r_dataRdata;
    assign data_err_o     = r_dataErr;
    assign mem_req_o      = (r_state == ISSUE);
    assign mem_addr_o     = r_memAddr;
    assign mem_we_o       = r_memWe;
    assign mem_be_o       = r_memBe;
    assign mem_wdata_o    = r_memWdata;
    assign busy_o         = (r_state != IDLE);

endmodule
